branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Resolution side of the local branch predictor.
- Tracks every fetched instruction's prediction in an in-order in-flight queue.
- When EX resolves the oldest instruction, compares the actual outcome to the prediction.
- On mismatch: issues a registered PC redirect plus a timed pipeline flush.
- For every resolved branch: drives the BHT/PHT/BTB update bus back to the predictor, and keeps saturating statistics counters.

Parameters:
- DEPTH, 4: in-flight queue entries (power of two, ≥2).
- FLUSH_CYCLES, 2: cycles flush stays high after a mispredict (≥1).
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- pred_push  in  1  fetch enqueues one instruction's prediction record
- pred_pc  in  32  PC of enqueued instruction
- pred_valid  in  1  predictor made a prediction (BPredValid)
- pred_taken  in  1  predicted direction (BPred)
- pred_target  in  32  predicted target (used only if pred_valid & pred_taken)
- q_full  out  1  queue full; fetch must stall
- res_valid  in  1  EX resolves the oldest queued instruction this cycle
- res_is_branch  in  1  resolved instruction is a branch
- res_taken  in  1  actual direction (PCSrc)
- res_target  in  32  actual branch target (PC_Branch)
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  32  corrected PC
- flush  out  1  squash younger pipeline stages
- upd_valid  out  1  one-cycle predictor update strobe
- upd_pc  out  32  PC of resolved branch
- upd_taken  out  1  actual direction for BHT/PHT training
- upd_target  out  32  actual target for BTB write
- branch_cnt  out  CNT_W  resolved branches
- mispred_cnt  out  CNT_W  mispredictions
- res_error  out  1  sticky: res_valid with empty queue, or push when full without pop

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Queue emptied; FSM to RUN.
  - All outputs 0: q_full, redirect_valid, redirect_pc, flush, upd_*, counters, res_error.
  - reset overrides every simultaneous event.
- Queue:
  - Circular FIFO with wrapping pointers and a count of 0..DEPTH.
  - q_full = (count == DEPTH), combinational from count.
  - Push and pop in the same cycle are both accepted, including when full: count unchanged and the pushed entry is stored.
  - Push when full without a pop is dropped and sets res_error.
- Pop (RUN state, res_valid=1, count>0): head entry E is compared with the result. mispredict is:
  - res_is_branch & !E.valid & res_taken, or
  - res_is_branch & E.valid & (E.taken != res_taken), or
  - res_is_branch & E.valid & E.taken & res_taken & (E.target != res_target), or
  - !res_is_branch & E.valid & E.taken.
- Correct PC = res_taken & res_is_branch ? res_target : E.pc + 4 (32-bit wrap).
- All outputs are registered; effects appear the cycle after the pop:
  - upd_valid = res_is_branch; upd_pc = E.pc; upd_taken = res_taken; upd_target = res_target.
  - branch_cnt +1 if branch; mispred_cnt +1 if mispredict. Both saturate at all-ones.
  - On mispredict: redirect_valid = 1 for one cycle, redirect_pc = correct PC, queue cleared (younger entries are wrong-path), FSM to FLUSH.
  - redirect_pc holds its last value when redirect_valid = 0.
- res_valid with count == 0: ignored except that it sets res_error.
- FSM:
  - RUN: normal push/pop.
  - FLUSH: flush = 1 for exactly FLUSH_CYCLES cycles, starting the cycle redirect_valid is high. pred_push and res_valid are ignored; no error is flagged. Then return to RUN.
- Push in the same cycle as a mispredicting pop is discarded; the queue is empty afterward.

Test Plan:
- Correct prediction:
  - Stimulus: reset; push {pc=0x100, valid=1, taken=1, target=0x200}; resolve {branch=1, taken=1, target=0x200}.
  - Response: next cycle upd_valid=1, upd_pc=0x100, upd_taken=1; redirect_valid=0; branch_cnt=1; mispred_cnt=0.
- Direction mispredict:
  - Stimulus: push 0x100 {valid=1, taken=1}, 0x104, 0x108; resolve head with taken=0.
  - Response: redirect_valid pulse with redirect_pc=0x104; flush high for 2 cycles; queue empty; mispred_cnt=1; pushes during flush dropped.
- Unpredicted taken:
  - Stimulus: push 0x40 {valid=0}; resolve {branch=1, taken=1, target=0x80}.
  - Response: redirect_pc=0x80; upd_target=0x80.
- Target mismatch and non-branch cases:
  - Predicted taken to 0x300, actual 0x310 → redirect to 0x310.
  - Non-branch with valid=0 → no redirect, upd_valid=0, branch_cnt unchanged.
- Full queue:
  - Fill 4 entries → q_full=1.
  - Simultaneous push+pop → count stays 4, FIFO order preserved.
  - Push without pop → dropped, res_error=1.
  - res_valid on empty queue → res_error=1.
- Reset mid-flush and counter saturation:
  - reset asserted during FLUSH → next cycle flush=0, queue empty.
  - With CNT_W=2, four mispredicts → mispred_cnt holds 3.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Bus between the fetch/EX pipeline (master) and the branch
//               resolve unit (slave): prediction records in, resolutions in,
//               redirect/flush/predictor-update/statistics out.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  // Prediction records from fetch
  logic             pred_push;
  logic [31:0]      pred_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             q_full;

  // Resolution from EX
  logic             res_valid;
  logic             res_is_branch;
  logic             res_taken;
  logic [31:0]      res_target;

  // Redirect / flush to the pipeline
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;

  // Predictor training bus
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;

  // Statistics and error status
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             res_error;

  modport master (
    output pred_push, pred_pc, pred_valid, pred_taken, pred_target,
    output res_valid, res_is_branch, res_taken, res_target,
    input  q_full, redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  branch_cnt, mispred_cnt, res_error
  );

  modport slave (
    input  pred_push, pred_pc, pred_valid, pred_taken, pred_target,
    input  res_valid, res_is_branch, res_taken, res_target,
    output q_full, redirect_valid, redirect_pc, flush,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output branch_cnt, mispred_cnt, res_error
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolution side of the local branch predictor. Holds each
//               fetched instruction's prediction in an in-order queue,
//               checks it against the EX outcome, and produces a registered
//               redirect, a timed flush, predictor updates and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_Q_W = $clog2(DEPTH + 1);
  localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CNT_Q_W-1:0] c_depth      = CNT_Q_W'(DEPTH);
  localparam logic [FC_W-1:0]    c_flush_init = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max    = {CNT_W{1'b1}};

  // Queue storage
  logic [31:0]        r_q_pc     [DEPTH];
  logic               r_q_valid  [DEPTH];
  logic               r_q_taken  [DEPTH];
  logic [31:0]        r_q_target [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_Q_W-1:0] r_count;

  // Control state
  state_t             r_state;
  state_t             w_state_next;
  logic [FC_W-1:0]    r_flush_cnt;
  logic [FC_W-1:0]    w_flush_cnt_next;
  logic               r_flush;
  logic               w_flush_next;

  // Registered outputs
  logic               r_redirect_valid;
  logic [31:0]        r_redirect_pc;
  logic               r_upd_valid;
  logic [31:0]        r_upd_pc;
  logic               r_upd_taken;
  logic [31:0]        r_upd_target;
  logic [CNT_W-1:0]   r_branch_cnt;
  logic [CNT_W-1:0]   r_mispred_cnt;
  logic               r_res_error;

  // Per-cycle decisions
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_mispred;
  logic               w_err_set;
  logic [31:0]        w_head_pc;
  logic               w_head_valid;
  logic               w_head_taken;
  logic [31:0]        w_head_target;
  logic [31:0]        w_correct_pc;

  assign w_full        = (r_count == c_depth);
  assign w_head_pc     = r_q_pc[r_rd_ptr];
  assign w_head_valid  = r_q_valid[r_rd_ptr];
  assign w_head_taken  = r_q_taken[r_rd_ptr];
  assign w_head_target = r_q_target[r_rd_ptr];

  // Where fetch should have gone: the real target if taken, else fall-through
  assign w_correct_pc = (bus.res_taken && bus.res_is_branch) ? bus.res_target
                                                             : (w_head_pc + 32'd4);

  // Next-state and per-cycle queue/flush decisions
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_flush_next     = r_flush;
    w_pop            = 1'b0;
    w_push           = 1'b0;
    w_mispred        = 1'b0;
    w_err_set        = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_pop = bus.res_valid && (r_count != '0);
        if (w_pop) begin
          if (bus.res_is_branch) begin
            w_mispred = (!w_head_valid && bus.res_taken)
                     || (w_head_valid && (w_head_taken != bus.res_taken))
                     || (w_head_valid && w_head_taken && bus.res_taken
                         && (w_head_target != bus.res_target));
          end else begin
            w_mispred = w_head_valid && w_head_taken;
          end
        end
        // A push alongside a mispredicting pop is wrong-path and discarded
        w_push    = bus.pred_push && !w_mispred && (!w_full || w_pop);
        w_err_set = (bus.res_valid && (r_count == '0))
                 || (bus.pred_push && w_full && !w_pop);
        if (w_mispred) begin
          w_state_next     = ST_FLUSH;
          w_flush_next     = 1'b1;
          w_flush_cnt_next = c_flush_init;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_next = ST_RUN;
          w_flush_next = 1'b0;
        end else begin
          w_flush_cnt_next = r_flush_cnt - FC_W'(1);
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_flush_next = 1'b0;
      end
    endcase
  end

  // FSM state, flush timer and flush output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_flush     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_flush     <= w_flush_next;
    end
  end

  // Queue entry storage; contents only matter between the pointers
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_q_pc[r_wr_ptr]     <= bus.pred_pc;
      r_q_valid[r_wr_ptr]  <= bus.pred_valid;
      r_q_taken[r_wr_ptr]  <= bus.pred_taken;
      r_q_target[r_wr_ptr] <= bus.pred_target;
    end
  end

  // Queue pointers and occupancy; a mispredict discards all younger entries
  always_ff @(posedge clk) begin
    if (reset || w_mispred) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_Q_W'(1);
        2'b01:   r_count <= r_count - CNT_Q_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Redirect, predictor update, statistics and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_pc         <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_target     <= '0;
      r_branch_cnt     <= '0;
      r_mispred_cnt    <= '0;
      r_res_error      <= 1'b0;
    end else begin
      r_redirect_valid <= w_mispred;
      r_upd_valid      <= w_pop && bus.res_is_branch;
      if (w_mispred) begin
        r_redirect_pc <= w_correct_pc;
        if (r_mispred_cnt != c_cnt_max) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_upd_pc     <= w_head_pc;
        r_upd_taken  <= bus.res_taken;
        r_upd_target <= bus.res_target;
        if (bus.res_is_branch && (r_branch_cnt != c_cnt_max))
          r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_err_set) r_res_error <= 1'b1;
    end
  end

  assign bus.q_full         = w_full;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush          = r_flush;
  assign bus.upd_valid      = r_upd_valid;
  assign bus.upd_pc         = r_upd_pc;
  assign bus.upd_taken      = r_upd_taken;
  assign bus.upd_target     = r_upd_target;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispred_cnt    = r_mispred_cnt;
  assign bus.res_error      = r_res_error;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit. A second
//               instance with 2-bit counters shares the same stimulus to
//               exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  branch_resolve_unit_if #(.CNT_W(16)) bus ();
  branch_resolve_unit_if #(.CNT_W(2))  sat_bus ();

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(sat_bus)
  );

  // The narrow-counter instance mirrors the main stimulus
  assign sat_bus.pred_push     = bus.pred_push;
  assign sat_bus.pred_pc       = bus.pred_pc;
  assign sat_bus.pred_valid    = bus.pred_valid;
  assign sat_bus.pred_taken    = bus.pred_taken;
  assign sat_bus.pred_target   = bus.pred_target;
  assign sat_bus.res_valid     = bus.res_valid;
  assign sat_bus.res_is_branch = bus.res_is_branch;
  assign sat_bus.res_taken     = bus.res_taken;
  assign sat_bus.res_target    = bus.res_target;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pred_push = 1'b0; bus.pred_pc = '0; bus.pred_valid = 1'b0;
    bus.pred_taken = 1'b0; bus.pred_target = '0;
    bus.res_valid = 1'b0; bus.res_is_branch = 1'b0; bus.res_taken = 1'b0;
    bus.res_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic v, input logic t,
                      input logic [31:0] tgt);
    bus.pred_push = 1'b1; bus.pred_pc = pc; bus.pred_valid = v;
    bus.pred_taken = t; bus.pred_target = tgt;
    step();
    bus.pred_push = 1'b0;
  endtask

  task automatic resolve(input logic br, input logic t, input logic [31:0] tgt);
    bus.res_valid = 1'b1; bus.res_is_branch = br; bus.res_taken = t;
    bus.res_target = tgt;
    step();
    bus.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.pred_push = 1'b1; bus.res_valid = 1'b1; bus.res_is_branch = 1'b1;
    bus.res_taken = 1'b1;
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.q_full !== 1'b0) begin errors++; $display("FAIL rst_q_full: got %0h want 0", bus.q_full); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid: got %0h want 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc: got %h want 0", bus.redirect_pc); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0h want 0", bus.flush); end
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL rst_upd_valid: got %0h want 0", bus.upd_valid); end
    checks++; if (bus.upd_pc !== 32'h0) begin errors++; $display("FAIL rst_upd_pc: got %h want 0", bus.upd_pc); end
    checks++; if (bus.branch_cnt !== 16'd0 || bus.mispred_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d want 0/0", bus.branch_cnt, bus.mispred_cnt); end
    checks++; if (bus.res_error !== 1'b0) begin errors++; $display("FAIL rst_res_error: got %0h want 0", bus.res_error); end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_correct_prediction();
    do_reset();
    push(32'h100, 1'b1, 1'b1, 32'h200);
    resolve(1'b1, 1'b1, 32'h200);
    checks++; if (bus.upd_valid !== 1'b1) begin errors++; $display("FAIL corr_upd_valid: got %0h want 1", bus.upd_valid); end
    checks++; if (bus.upd_pc !== 32'h100) begin errors++; $display("FAIL corr_upd_pc: got %h want 00000100", bus.upd_pc); end
    checks++; if (bus.upd_taken !== 1'b1) begin errors++; $display("FAIL corr_upd_taken: got %0h want 1", bus.upd_taken); end
    checks++; if (bus.upd_target !== 32'h200) begin errors++; $display("FAIL corr_upd_target: got %h want 00000200", bus.upd_target); end
    checks++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL corr_no_redirect: got rv=%0h fl=%0h want 0/0", bus.redirect_valid, bus.flush); end
    checks++; if (bus.branch_cnt !== 16'd1 || bus.mispred_cnt !== 16'd0) begin errors++; $display("FAIL corr_counters: got %0d/%0d want 1/0", bus.branch_cnt, bus.mispred_cnt); end
    step();
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL corr_upd_pulse: got %0h want 0", bus.upd_valid); end
  endtask

  task automatic test_direction_mispredict();
    do_reset();
    push(32'h100, 1'b1, 1'b1, 32'h200);
    push(32'h104, 1'b0, 1'b0, 32'h0);
    push(32'h108, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h200);
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL dir_redirect_valid: got %0h want 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h104) begin errors++; $display("FAIL dir_redirect_pc: got %h want 00000104", bus.redirect_pc); end
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL dir_flush_c1: got %0h want 1", bus.flush); end
    checks++; if (bus.mispred_cnt !== 16'd1 || bus.branch_cnt !== 16'd1) begin errors++; $display("FAIL dir_counters: got %0d/%0d want 1/1", bus.branch_cnt, bus.mispred_cnt); end
    checks++; if (bus.upd_valid !== 1'b1 || bus.upd_taken !== 1'b0) begin errors++; $display("FAIL dir_upd: got v=%0h t=%0h want 1/0", bus.upd_valid, bus.upd_taken); end
    // Push and resolve during the flush window: both ignored, no error
    bus.pred_push = 1'b1; bus.pred_pc = 32'h10C; bus.pred_valid = 1'b0;
    bus.res_valid = 1'b1; bus.res_is_branch = 1'b1; bus.res_taken = 1'b1;
    bus.res_target = 32'h500;
    step();
    checks++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL dir_flush_c2: got fl=%0h rv=%0h want 1/0", bus.flush, bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h104) begin errors++; $display("FAIL dir_redirect_hold: got %h want 00000104", bus.redirect_pc); end
    checks++; if (bus.upd_valid !== 1'b0 || bus.res_error !== 1'b0) begin errors++; $display("FAIL dir_flush_ignore1: got uv=%0h err=%0h want 0/0", bus.upd_valid, bus.res_error); end
    step();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL dir_flush_end: got %0h want 0", bus.flush); end
    checks++; if (bus.upd_valid !== 1'b0 || bus.res_error !== 1'b0 || bus.branch_cnt !== 16'd1) begin errors++; $display("FAIL dir_flush_ignore2: got uv=%0h err=%0h bc=%0d want 0/0/1", bus.upd_valid, bus.res_error, bus.branch_cnt); end
    // Back in RUN with an empty queue: a resolve finds nothing
    bus.pred_push = 1'b0;
    step();
    bus.res_valid = 1'b0;
    checks++; if (bus.res_error !== 1'b1) begin errors++; $display("FAIL dir_empty_error: got %0h want 1", bus.res_error); end
    checks++; if (bus.upd_valid !== 1'b0 || bus.branch_cnt !== 16'd1 || bus.q_full !== 1'b0) begin errors++; $display("FAIL dir_queue_empty: got uv=%0h bc=%0d qf=%0h want 0/1/0", bus.upd_valid, bus.branch_cnt, bus.q_full); end
  endtask

  task automatic test_unpredicted_taken();
    do_reset();
    push(32'h40, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b1, 32'h80);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin errors++; $display("FAIL unp_redirect: got v=%0h pc=%h want 1/00000080", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.upd_target !== 32'h80 || bus.upd_pc !== 32'h40) begin errors++; $display("FAIL unp_upd: got tgt=%h pc=%h want 00000080/00000040", bus.upd_target, bus.upd_pc); end
    checks++; if (bus.mispred_cnt !== 16'd1) begin errors++; $display("FAIL unp_mispred_cnt: got %0d want 1", bus.mispred_cnt); end
    step();
    step();
  endtask

  task automatic test_target_and_nonbranch();
    do_reset();
    push(32'h120, 1'b1, 1'b1, 32'h300);
    resolve(1'b1, 1'b1, 32'h310);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h310) begin errors++; $display("FAIL tgt_redirect: got v=%0h pc=%h want 1/00000310", bus.redirect_valid, bus.redirect_pc); end
    step();
    step();
    push(32'h50, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 1'b0, 32'h0);
    checks++; if (bus.redirect_valid !== 1'b0 || bus.upd_valid !== 1'b0) begin errors++; $display("FAIL nb_quiet: got rv=%0h uv=%0h want 0/0", bus.redirect_valid, bus.upd_valid); end
    checks++; if (bus.branch_cnt !== 16'd1 || bus.mispred_cnt !== 16'd1) begin errors++; $display("FAIL nb_counters: got %0d/%0d want 1/1", bus.branch_cnt, bus.mispred_cnt); end
    push(32'h60, 1'b1, 1'b1, 32'h90);
    resolve(1'b0, 1'b0, 32'h0);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h64) begin errors++; $display("FAIL nb_pred_taken: got v=%0h pc=%h want 1/00000064", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.mispred_cnt !== 16'd2 || bus.branch_cnt !== 16'd1 || bus.upd_valid !== 1'b0) begin errors++; $display("FAIL nb_pred_counters: got mc=%0d bc=%0d uv=%0h want 2/1/0", bus.mispred_cnt, bus.branch_cnt, bus.upd_valid); end
    step();
    step();
  endtask

  task automatic test_full_queue();
    logic [31:0] exp_pc;
    do_reset();
    push(32'h1000, 1'b0, 1'b0, 32'h0);
    push(32'h1004, 1'b0, 1'b0, 32'h0);
    push(32'h1008, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.q_full !== 1'b0) begin errors++; $display("FAIL full_three: got %0h want 0", bus.q_full); end
    push(32'h100C, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.q_full !== 1'b1) begin errors++; $display("FAIL full_four: got %0h want 1", bus.q_full); end
    // Simultaneous push and pop while full
    bus.pred_push = 1'b1; bus.pred_pc = 32'h1010; bus.pred_valid = 1'b0; bus.pred_taken = 1'b0;
    resolve(1'b1, 1'b0, 32'h0);
    bus.pred_push = 1'b0;
    checks++; if (bus.q_full !== 1'b1 || bus.upd_pc !== 32'h1000 || bus.upd_valid !== 1'b1) begin errors++; $display("FAIL full_pushpop: got qf=%0h pc=%h uv=%0h want 1/00001000/1", bus.q_full, bus.upd_pc, bus.upd_valid); end
    checks++; if (bus.res_error !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL full_pushpop_ok: got err=%0h rv=%0h want 0/0", bus.res_error, bus.redirect_valid); end
    push(32'h1014, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.res_error !== 1'b1 || bus.q_full !== 1'b1) begin errors++; $display("FAIL full_drop: got err=%0h qf=%0h want 1/1", bus.res_error, bus.q_full); end
    exp_pc = 32'h1004;
    for (int i = 0; i < 4; i++) begin
      resolve(1'b1, 1'b0, 32'h0);
      checks++; if (bus.upd_pc !== exp_pc || bus.upd_valid !== 1'b1) begin errors++; $display("FAIL full_order%0d: got pc=%h uv=%0h want %h/1", i, bus.upd_pc, bus.upd_valid, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
    checks++; if (bus.q_full !== 1'b0 || bus.branch_cnt !== 16'd5) begin errors++; $display("FAIL full_drained: got qf=%0h bc=%0d want 0/5", bus.q_full, bus.branch_cnt); end
    resolve(1'b1, 1'b0, 32'h0);
    checks++; if (bus.upd_valid !== 1'b0 || bus.branch_cnt !== 16'd5) begin errors++; $display("FAIL full_dropped_gone: got uv=%0h bc=%0d want 0/5", bus.upd_valid, bus.branch_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    push(32'h200, 1'b1, 1'b1, 32'h240);
    push(32'h204, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h0);
    checks++; if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h204) begin errors++; $display("FAIL rmf_pre: got fl=%0h pc=%h want 1/00000204", bus.flush, bus.redirect_pc); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.mispred_cnt !== 16'd0) begin errors++; $display("FAIL rmf_reset: got fl=%0h rv=%0h mc=%0d want 0/0/0", bus.flush, bus.redirect_valid, bus.mispred_cnt); end
    resolve(1'b1, 1'b1, 32'h0);
    checks++; if (bus.upd_valid !== 1'b0 || bus.res_error !== 1'b1) begin errors++; $display("FAIL rmf_empty_run: got uv=%0h err=%0h want 0/1", bus.upd_valid, bus.res_error); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'h300 + 32'(i * 16), 1'b1, 1'b1, 32'h400);
      resolve(1'b1, 1'b0, 32'h0);
      step();
      step();
    end
    checks++; if (bus.mispred_cnt !== 16'd4) begin errors++; $display("FAIL sat_wide: got %0d want 4", bus.mispred_cnt); end
    checks++; if (sat_bus.mispred_cnt !== 2'd3) begin errors++; $display("FAIL sat_mispred: got %0d want 3", sat_bus.mispred_cnt); end
    checks++; if (sat_bus.branch_cnt !== 2'd3) begin errors++; $display("FAIL sat_branch: got %0d want 3", sat_bus.branch_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_correct_prediction();
    test_direction_mispredict();
    test_unpredicted_taken();
    test_target_and_nonbranch();
    test_full_queue();
    test_reset_mid_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
